// File: rtl/ifu_axi_rd_bridge.sv
// ifu_axi_rd_bridge
// ---------------------------------------------------------------------------
// Turns a single-beat instruction-fetch request (valid/ready) into one AXI4
// read transaction and returns the aligned read word and RRESP to the fetch
// stage. Only one transaction is in flight at a time.
//
// Handshakes:
//   AR and R channels use standard AXI valid/ready. A transfer happens on a
//   rising edge where both are high. arvalid is never withdrawn before
//   arready. araddr and arsize stay constant while arvalid is high.
//   On the fetch side, the request is taken on the edge where if_valid=1 and
//   the bridge is IDLE. if_ready is a one-cycle Moore pulse in RESP, and
//   if_data_read/if_resp are valid in that cycle.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   if_valid/if_addr/     fetch request: PC and AXI size code
//   if_size
//   flush                 drop the result of the fetch in flight
//   if_ready              completion pulse
//   if_data_read/if_resp  aligned read data and RRESP of the last beat taken
//   ar*                   AXI read address channel (master side)
//   r*                    AXI read data channel (master side)
//   dbg_state_o           current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
// ---------------------------------------------------------------------------
module ifu_axi_rd_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int FETCH_ID = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [63:0]       if_addr,
  input  logic [1:0]        if_size,
  input  logic              flush,
  output logic [DATA_W-1:0] if_data_read,
  output logic [1:0]        if_resp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  output logic [1:0]        dbg_state_o
);

  // Byte-offset bits of the address within one data beat.
  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [2:0]          arsize_q, arsize_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          resp_q, resp_d;

  // Upper PC bits beyond ADDR_W and the returned ID are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{if_addr, rid};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      arsize_q <= '0;
      drop_q   <= 1'b0;
      data_q   <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    drop_d   = drop_q;
    data_d   = data_q;
    resp_d   = resp_q;
    case (state_q)
      S_IDLE: begin
        if (if_valid) begin
          state_d  = S_ADDR;
          araddr_d = if_addr[ADDR_W-1:0];
          arsize_d = {1'b0, if_size};
          drop_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (flush) drop_d = 1'b1;
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (flush) drop_d = 1'b1;
        // Beats without rlast are not expected for arlen=0; they are consumed
        // and ignored so the channel never stalls.
        if (rvalid && rlast) begin
          data_d  = rdata >> {araddr_q[OFF_W-1:0], 3'b000};
          resp_d  = rresp;
          // A flush arriving with the last beat still drops the result.
          state_d = (drop_q || flush) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All handshake outputs are decoded from state only.
  assign arvalid      = (state_q == S_ADDR);
  assign rready       = (state_q == S_DATA);
  assign if_ready     = (state_q == S_RESP);
  assign araddr       = araddr_q;
  assign arsize       = arsize_q;
  assign arid         = ID_W'(FETCH_ID);
  assign arlen        = 8'd0;
  assign arburst      = 2'b01;
  assign arprot       = 3'b100;
  assign if_data_read = data_q;
  assign if_resp      = resp_q;
  assign dbg_state_o  = state_q;

endmodule
